muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer for the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from the execute stage and runs 32 shift-add or restore-subtract iterations. It returns a 64-bit {HI,LO} result with a write_hilo strobe that matches the write-back HI/LO encoding (2'b11 = write both). It also raises a pipeline stall while a result is pending and a later instruction needs HI/LO or the unit.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_ctrl_if.sv | 27 ++
 rtl/muldiv_datapath.sv | 112 +++++++++++
 rtl/muldiv_ctrl.sv | 91 +++++++++
 tb/tb_muldiv_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide unit.
//   - OP_*  : execute-stage operation codes (op[1] selects divide, op[0] unsigned)
//   - S_*   : sequencer state encodings
//   - WH_*  : HI/LO write-enable encoding, shared with the write-back stage
//   - helpers decoding the op field
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_MUL  = 2'b01;
  localparam logic [1:0] S_DIV  = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  localparam logic [1:0] WH_NONE = 2'b00;
  localparam logic [1:0] WH_HI   = 2'b10;
  localparam logic [1:0] WH_LO   = 2'b01;
  localparam logic [1:0] WH_BOTH = 2'b11;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: execute-stage <-> multiply/divide unit signal bundle.
//   master (execute stage): drives start, op, src_a, src_b, cancel, hilo_read_req
//                           observes busy, done, hilo, write_hilo, stall
//   slave  (muldiv_ctrl)  : the mirror image
interface muldiv_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        hilo_read_req;
  logic        busy;
  logic        done;
  logic [63:0] hilo;
  logic [1:0]  write_hilo;
  logic        stall;

  modport master (
    output start, op, src_a, src_b, cancel, hilo_read_req,
    input  busy, done, hilo, write_hilo, stall
  );

  modport slave (
    input  start, op, src_a, src_b, cancel, hilo_read_req,
    output busy, done, hilo, write_hilo, stall
  );
endinterface

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: operand/accumulator registers, one shift-add or
// restoring-divide step per enabled cycle, and the final sign fix-up.
//   clk        : clock
//   load_i     : capture operand magnitudes and result signs
//   op_i       : operation code (muldiv_pkg OP_*)
//   src_a_i    : multiplicand / dividend
//   src_b_i    : multiplier / divisor
//   step_mul_i : perform one multiply step
//   step_div_i : perform one divide step
//   result_o   : sign-corrected {HI,LO}
// The accumulator is shared: for multiply it holds {partial product, multiplier},
// for divide it holds {remainder, dividend/quotient}. Data registers carry no reset.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  load_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_W-1:0]     src_a_i,
  input  logic [DATA_W-1:0]     src_b_i,
  input  logic                  step_mul_i,
  input  logic                  step_div_i,
  output logic [2*DATA_W-1:0]   result_o
);

  localparam int W = DATA_W;

  function automatic logic [W-1:0] mag(input logic signed [W-1:0] x, input logic sgn);
    return (sgn && x < 0) ? -x : x;
  endfunction

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic           neg_quo_q, neg_quo_d;   // product or quotient negative
  logic           neg_rem_q, neg_rem_d;   // remainder negative
  logic           is_div_q, is_div_d;
  logic           divz_q, divz_d;

  logic           signed_op;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     addend, sum;
  logic [W:0]     shifted;
  logic [W+1:0]   diff;
  logic           ge;
  logic [W-1:0]   new_rem;

  assign signed_op = op_is_signed(op_i);
  assign mag_a     = mag(src_a_i, signed_op);
  assign mag_b     = mag(src_b_i, signed_op);

  // Multiply step: add multiplicand when the multiplier LSB is set, then shift right
  assign addend = acc_q[0] ? {1'b0, opnd_q} : '0;
  assign sum    = {1'b0, acc_q[2*W-1:W]} + addend;

  // Divide step: shift remainder:quotient left by one, trial-subtract the divisor
  assign shifted = acc_q[2*W-1:W-1];
  assign diff    = {1'b0, shifted} - {2'b00, opnd_q};
  assign ge      = ~diff[W+1];
  assign new_rem = ge ? diff[W-1:0] : shifted[W-1:0];

  always_comb begin
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    divz_d    = divz_q;
    if (load_i) begin
      acc_d     = {{W{1'b0}}, mag_a};
      opnd_d    = mag_b;
      neg_quo_d = signed_op & (src_a_i[W-1] ^ src_b_i[W-1]);
      neg_rem_d = signed_op & src_a_i[W-1];
      is_div_d  = op_is_div(op_i);
      divz_d    = (src_b_i == '0);
    end else if (step_mul_i) begin
      acc_d = {sum, acc_q[W-1:1]};
    end else if (step_div_i) begin
      acc_d = {new_rem, acc_q[W-2:0], ge};
    end
  end

  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    opnd_q    <= opnd_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
    is_div_q  <= is_div_d;
    divz_q    <= divz_d;
  end

  // Divide by zero keeps the raw all-ones quotient; the remainder still takes the
  // dividend's sign, which reproduces the original dividend in HI.
  always_comb begin
    if (is_div_q) begin
      result_o = {neg_w(acc_q[2*W-1:W], neg_rem_q),
                  divz_q ? acc_q[W-1:0] : neg_w(acc_q[W-1:0], neg_quo_q)};
    end else begin
      result_o = neg_2w(acc_q, neg_quo_q);
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer for the MIPS pipeline.
//   clk : clock
//   rst : synchronous active-high reset (control state only)
//   bus : muldiv_ctrl_if.slave
//         start/op/src_a/src_b issue an operation from IDLE or DONE
//         cancel aborts (and suppresses the HI/LO write in DONE)
//         hilo_read_req signals a HI/LO access in decode
//         busy while iterating, done one-cycle result pulse with hilo,
//         write_hilo = WH_BOTH on an uncancelled done, stall freezes IF/ID/EX
// Issue at edge t gives done during the cycle after edge t+ITER.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(ITER);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             last_iter;
  logic             step_mul, step_div;
  logic             busy, done;
  logic [63:0]      result;

  // New work is taken only when no operation is iterating; cancel wins over start
  assign accept    = bus.start & ~bus.cancel & (state_q == S_IDLE | state_q == S_DONE);
  assign last_iter = (cnt_q == CNT_W'(ITER - 1));
  assign step_mul  = (state_q == S_MUL) & ~bus.cancel;
  assign step_div  = (state_q == S_DIV) & ~bus.cancel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = op_is_div(bus.op) ? S_DIV : S_MUL;
          cnt_d   = '0;
        end
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (last_iter) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.cancel) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  muldiv_datapath #(.DATA_W(32)) u_dp (
    .clk        (clk),
    .load_i     (accept),
    .op_i       (bus.op),
    .src_a_i    (bus.src_a),
    .src_b_i    (bus.src_b),
    .step_mul_i (step_mul),
    .step_div_i (step_div),
    .result_o   (result)
  );

  assign busy = (state_q == S_MUL) | (state_q == S_DIV);
  assign done = (state_q == S_DONE);

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.hilo       = done ? result : '0;
  assign bus.write_hilo = (done & ~bus.cancel) ? WH_BOTH : WH_NONE;
  // Drops in DONE so a dependent MFHI/MFLO reaches write-back after HI/LO update
  assign bus.stall      = busy & (bus.start | bus.hilo_read_req);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized and directed stimulus with a scoreboard; a
// negedge monitor pops expected results whenever the unit presents done.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  muldiv_ctrl_if bus ();

  muldiv_ctrl #(.ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] hilo;
    logic [1:0]  wh;
    int          at;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb2;
    longint unsigned ua, ub;
    logic [31:0]     q, r;
    case (op)
      OP_MULT: begin
        sa = $signed(a); sb2 = $signed(b);
        return sa * sb2;
      end
      OP_MULTU: begin
        ua = a; ub = b;
        return ua * ub;
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == OP_DIVU) begin
          q = a / b; r = a % b;
        end else begin
          sa = $signed(a); sb2 = $signed(b);
          q = 32'(sa / sb2); r = 32'(sa % sb2);
        end
        return {r, q};
      end
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [1:0] wh, input string name);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (push) sb.push_back('{model(op, a, b), wh, cyc + 32, name});
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) tick(1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every done is matched against the oldest expected result
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got hilo %h, required no result", bus.hilo);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_hilo"}, bus.hilo, mon_e.hilo);
          check({mon_e.name, "_wh"}, 64'(bus.write_hilo), 64'(mon_e.wh));
          check({mon_e.name, "_cycle"}, 64'(cyc), 64'(mon_e.at));
        end
      end else begin
        check("wh_without_done", 64'(bus.write_hilo), 64'(WH_NONE));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  logic [1:0]  d_op [6] = '{OP_MULT, OP_MULTU, OP_DIVU, OP_DIV, OP_DIV, OP_DIV};
  logic [31:0] d_a  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
  logic [31:0] d_b  [6] = '{32'd7, 32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    bus.start = 0; bus.op = 0; bus.src_a = 0; bus.src_b = 0;
    bus.cancel = 0; bus.hilo_read_req = 1;
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hilo", bus.hilo, 64'd0);
    check("rst_wh", 64'(bus.write_hilo), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.hilo_read_req = 0;
    mon_en = 1;

    // Directed results from the test plan
    for (int i = 0; i < 6; i++) begin
      issue(d_op[i], d_a[i], d_b[i], 1, WH_BOTH, $sformatf("directed%0d", i));
      wait_drain(40);
    end
    check("plan_mult", model(OP_MULT, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);

    // Stall window with a HI/LO reader, and a start that must be ignored
    issue(OP_DIV, $urandom, $urandom_range(1, 1000), 1, WH_BOTH, "stall_div");
    for (int k = 0; k <= 33; k++) begin
      bus.hilo_read_req = (k >= 2);
      bus.start = (k == 9);
      bus.op = OP_MULTU; bus.src_a = $urandom; bus.src_b = $urandom;
      @(negedge clk);
      check($sformatf("stall_k%0d", k), 64'(bus.stall), 64'((k >= 2 && k <= 31) ? 1 : 0));
      check($sformatf("busy_k%0d", k), 64'(bus.busy), 64'((k <= 31) ? 1 : 0));
      @(posedge clk); #1;
    end
    bus.start = 0; bus.hilo_read_req = 0;
    wait_drain(5);

    // Cancel mid-operation, then a fresh MULT
    issue(OP_MULT, $urandom, $urandom, 0, WH_NONE, "cancelled");
    tick(14);
    bus.cancel = 1;
    tick(1);
    bus.cancel = 0;
    @(negedge clk);
    check("cancel_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    issue(OP_MULT, 32'd2, 32'd3, 1, WH_BOTH, "after_cancel");
    wait_drain(40);

    // Back-to-back issue during DONE
    issue(OP_DIVU, $urandom, $urandom_range(1, 50000), 1, WH_BOTH, "b2b_first");
    tick(32);
    issue(OP_MULTU, 32'd1, 32'd1, 1, WH_BOTH, "b2b_second");
    wait_drain(40);

    // Cancel during DONE: done pulses, no write
    issue(OP_MULT, $urandom, $urandom, 1, WH_NONE, "cancel_in_done");
    tick(32);
    bus.cancel = 1;
    tick(1);
    bus.cancel = 0;
    wait_drain(5);

    // Reset mid-operation: no result may appear
    issue(OP_DIV, $urandom, $urandom, 0, WH_NONE, "reset_abort");
    tick(19);
    rst = 1;
    tick(1);
    rst = 0;
    bus.hilo_read_req = 1;
    @(negedge clk);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_wh", 64'(bus.write_hilo), 64'd0);
    check("midrst_stall", 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    bus.hilo_read_req = 0;
    tick(40);

    // Randomized operations
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      issue(rop, ra, rb, 1, WH_BOTH, $sformatf("rand%0d", i));
      wait_drain(40);
    end

    wait_drain(80);
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
